// File: rtl/regfile_write_buffer_pkg.sv
// Shared core parameters for the deferred register-file write buffer.
// XLEN and REG_ADDR_W match the core datapath; WB_DEPTH is the default buffer size.
package regfile_write_buffer_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_DEPTH   = 4;
endpackage

// File: rtl/regfile_write_buffer_wb_fifo.sv
// FIFO of deferred register writes: storage, pointers and occupancy count.
// Every entry's address and valid flag are exposed so the parent can run hazard compares.
module wb_fifo
  import regfile_write_buffer_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              flush,
  input  logic [REG_ADDR_W-1:0]             push_rd,
  input  logic [XLEN-1:0]                   push_data,
  output logic [REG_ADDR_W-1:0]             head_rd,
  output logic [XLEN-1:0]                   head_data,
  output logic [CNT_W-1:0]                  count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_rd,
  output logic [DEPTH-1:0]                  entry_valid
);

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  // Entry contents are qualified by the valid window, so they need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= push_rd;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count     = count_reg;
  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // An entry is live when its distance from the head (mod DEPTH) is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_reg;
      assign entry_rd[gi]    = rd_mem[gi];
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    end
  endgenerate

endmodule

// File: rtl/regfile_write_buffer.sv
// Buffers late register-file writes and drains them into idle write-port cycles.
// Core writeback always owns the port; decode reads are flagged when a buffered write is pending.
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_rd,
  input  logic [XLEN-1:0]       core_wd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hit1,
  output logic                  hit2,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  WE3,
  output logic [CNT_W-1:0]      count
);

  logic                             push;
  logic                             pop;
  logic                             nonempty;
  logic [REG_ADDR_W-1:0]            head_rd;
  logic [XLEN-1:0]                  head_data;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0]                 match1;
  logic [DEPTH-1:0]                 match2;

  assign nonempty = (count != '0);
  assign in_ready = rst && (count < CNT_W'(DEPTH)) && !flush;
  // Writes to x0 are accepted but never stored.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign pop      = rst && !core_we && nonempty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .push_rd     (in_rd),
    .push_data   (in_data),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (rst) begin
      if (core_we) begin
        WE3 = 1'b1;
        A3  = core_rd;
        WD3 = core_wd;
      end else if (nonempty) begin
        WE3 = 1'b1;
        A3  = head_rd;
        WD3 = head_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign match1[gi] = entry_valid[gi] && (entry_rd[gi] == rs1);
      assign match2[gi] = entry_valid[gi] && (entry_rd[gi] == rs2);
    end
  endgenerate

  assign hit1 = rst && (rs1 != '0) && (|match1);
  assign hit2 = rst && (rs2 != '0) && (|match2);

endmodule

// File: doc/regfile_write_buffer.md
REGFILE_WRITE_BUFFER -- requirements
Module: regfile_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  deferred-write request (e.g. late load data) present.
REQ-005 SHALL have port in_ready  output  1  buffer can accept a request this cycle.
REQ-006 SHALL have port in_rd  input  5  destination register address.
REQ-007 SHALL have port in_data  input  32  destination register data.
REQ-008 SHALL have port core_we  input  1  core writeback claims register-file write port this cycle.
REQ-009 SHALL have port core_rd  input  5  core writeback address.
REQ-010 SHALL have port core_wd  input  32  core writeback data.
REQ-011 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-012 SHALL have ports rs1, rs2  input  5 each  register addresses being read by decode.
REQ-013 SHALL have ports hit1, hit2  output  1 each  a buffered entry targets rs1 / rs2.
REQ-014 SHALL have ports A3 output 5, WD3 output 32, WE3 output 1  register-file write port.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  number of valid buffered entries.

Function
REQ-016 SHALL accept a request on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-017 SHALL drive in_ready = (count < DEPTH) && !flush, combinationally; no pass-through when full, even with a same-cycle drain.
REQ-018 SHALL accept a request with in_rd=0 and discard it: no entry stored, count unchanged.
REQ-019 SHALL store entries in FIFO order and drain only from the oldest entry (head).
REQ-020 SHALL, when core_we=1, drive WE3=1, A3=core_rd, WD3=core_wd, with no drain that cycle.
REQ-021 SHALL, when core_we=0 and count>0, drive WE3=1, A3/WD3 from head, and pop head on that edge.
REQ-022 SHALL, when core_we=0 and count=0, drive WE3=0, A3=0, WD3=0.
REQ-023 SHALL make the write-port mux combinational: a request accepted at edge N is written to the register file no earlier than edge N+1.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL drive hitK=1 iff rsK!=0 and any valid entry has rd==rsK; combinational.
REQ-027 SHALL, on flush=1, set count=0 and clear pointers at the edge; a same-cycle drain still writes its head entry, and a same-cycle push is refused.
REQ-028 SHALL NOT coalesce entries; duplicate rd entries drain in order, so the last value wins.

Reset
REQ-029 SHALL, while rst=0, immediately force count=0, pointers=0, WE3=0, hit1=hit2=0, and in_ready=0.
REQ-030 SHALL drop all buffered entries on a reset asserted mid-operation; entry data storage need not be reset.
REQ-031 SHALL permit acceptance on the first rising edge after rst deasserts.

Structure
REQ-032 SHALL take XLEN=32, REG_ADDR_W=5 and the DEPTH default from the shared core package.
REQ-033 SHALL implement storage, pointers and count in one sub-module wb_fifo; arbitration and hazard compare stay in the top module.

Verification
REQ-034 Push (rd=5, data=0x000000C8), core_we=0 -> next cycle WE3=1, A3=5, WD3=0xC8; count 1 -> 0.
REQ-035 core_we=1 for 3 cycles while pushing rd=1,2,3 -> port shows core_rd/core_wd; count reaches 3; entries then drain in order 1,2,3.
REQ-036 Hold core_we=1, push DEPTH entries -> in_ready=0 at count=4; a 5th request is not accepted; the first drain re-raises in_ready next cycle.
REQ-037 Push rd=0, data=0xFFFFFFFF -> count stays 0, WE3 never asserts with A3=0 from the buffer.
REQ-038 Buffer rd=9; set rs1=9, rs2=6 -> hit1=1, hit2=0; after drain, hit1=0.
REQ-039 With count=3, assert flush in one case and rst=0 mid-cycle in another -> count=0, and WE3=0 immediately under reset.
